// File: rtl/edge_pkg.sv
// Shared constants for the edge-bitmap frame buffer: geometry, window placement,
// RGB565 colours and the constant-width row multiplier.
package edge_pkg;

    localparam int HOR_SCREEN  = 800;
    localparam int VERT_SCREEN = 480;
    localparam int EDGE_W      = 158;
    localparam int EDGE_H      = 158;
    localparam int X0          = 321;
    localparam int Y0          = 161;
    localparam int ADDR_W      = 15;

    localparam logic [15:0] FG     = 16'hFFFF;
    localparam logic [15:0] BG_IN  = 16'h0000;
    localparam logic [15:0] BG_OUT = 16'h001F;

    typedef logic [ADDR_W-1:0] addr_t;

    // row * 158 as shift-add: 158 = 128 + 16 + 8 + 4 + 2
    function automatic addr_t row_base(input logic [7:0] row);
        addr_t r;
        r = addr_t'(row);
        return (r << 7) + (r << 4) + (r << 3) + (r << 2) + (r << 1);
    endfunction

endpackage

// File: rtl/edge_bitmap_ram.sv
// Two 1-bit bitmap banks in one simple dual-port array; the bank bit is the address MSB.
module edge_bitmap_ram
    import edge_pkg::*;
(
    input  logic            clk,
    input  logic            we,
    input  logic [ADDR_W:0] waddr,
    input  logic            wdata,
    input  logic [ADDR_W:0] raddr,
    output logic            rdata
);

    logic mem [0:(2**(ADDR_W+1))-1];
    logic rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/edge_frame_buf.sv
// Ping-pong edge bitmap: captures the Sobel edge stream into one bank while the other
// bank is served as RGB565 to the LCD; banks swap only on vsync_tick.
module edge_frame_buf
    import edge_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        edge_bit,
    input  logic        edge_valid,
    input  logic        frame_sync,
    input  logic        vsync_tick,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    output logic [15:0] pix_data,
    output logic        frame_done,
    output logic        frame_dropped,
    output logic        disp_bank
);

    logic [7:0] wcol_q, wcol_d, wrow_q, wrow_d;
    logic       wr_bank_q, wr_bank_d, disp_bank_q, disp_bank_d;
    logic       ready_q, ready_d, disp_ok_q, disp_ok_d, fr_en_q, fr_en_d;
    logic       frame_done_q, frame_done_d, frame_dropped_q, frame_dropped_d;
    logic       win_q, win_d, show_q, out_en_q;
    logic       at_origin, at_last, fr_en_eff, we, rd_bit;
    logic [9:0] dx, dy;
    logic [ADDR_W:0] waddr, raddr;

    assign at_origin = (wcol_q == '0) && (wrow_q == '0);
    assign at_last   = (wcol_q == 8'(EDGE_W-1)) && (wrow_q == 8'(EDGE_H-1));
    // The frame-start decision must use this cycle's ready, not the latched fr_en
    assign fr_en_eff = at_origin ? !ready_q : fr_en_q;

    always_comb begin
        wcol_d          = wcol_q;
        wrow_d          = wrow_q;
        wr_bank_d       = wr_bank_q;
        disp_bank_d     = disp_bank_q;
        ready_d         = ready_q;
        disp_ok_d       = disp_ok_q;
        fr_en_d         = fr_en_q;
        frame_done_d    = 1'b0;
        frame_dropped_d = 1'b0;
        we              = 1'b0;

        if (vsync_tick && ready_q) begin
            disp_bank_d = wr_bank_q;
            wr_bank_d   = ~wr_bank_q;
            ready_d     = 1'b0;
            disp_ok_d   = 1'b1;
        end

        if (frame_sync) begin
            wcol_d = '0;
            wrow_d = '0;
        end else if (edge_valid) begin
            if (at_origin) begin
                fr_en_d = !ready_q;
            end
            we = fr_en_eff;
            if (wcol_q == 8'(EDGE_W-1)) begin
                wcol_d = '0;
                wrow_d = at_last ? '0 : wrow_q + 8'd1;
            end else begin
                wcol_d = wcol_q + 8'd1;
            end
            if (at_last) begin
                if (fr_en_eff) begin
                    ready_d      = 1'b1;
                    frame_done_d = 1'b1;
                end else begin
                    frame_dropped_d = 1'b1;
                end
            end
        end
    end

    assign waddr = {wr_bank_q, row_base(wrow_q) + addr_t'(wcol_q)};

    // Unsigned wrap makes left/above-window coordinates huge, so one compare covers both sides
    assign dx    = pix_x - 10'(X0);
    assign dy    = pix_y - 10'(Y0);
    assign win_d = (dx < 10'(EDGE_W)) && (dy < 10'(EDGE_H)) &&
                   (pix_x < 10'(HOR_SCREEN)) && (pix_y < 10'(VERT_SCREEN));
    assign raddr = {disp_bank_q, row_base(dy[7:0]) + addr_t'(dx[7:0])};

    edge_bitmap_ram u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (edge_bit),
        .raddr (raddr),
        .rdata (rd_bit)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wcol_q          <= '0;
            wrow_q          <= '0;
            wr_bank_q       <= 1'b0;
            disp_bank_q     <= 1'b1;
            ready_q         <= 1'b0;
            disp_ok_q       <= 1'b0;
            fr_en_q         <= 1'b1;
            frame_done_q    <= 1'b0;
            frame_dropped_q <= 1'b0;
            win_q           <= 1'b0;
            show_q          <= 1'b0;
            out_en_q        <= 1'b0;
        end else begin
            wcol_q          <= wcol_d;
            wrow_q          <= wrow_d;
            wr_bank_q       <= wr_bank_d;
            disp_bank_q     <= disp_bank_d;
            ready_q         <= ready_d;
            disp_ok_q       <= disp_ok_d;
            fr_en_q         <= fr_en_d;
            frame_done_q    <= frame_done_d;
            frame_dropped_q <= frame_dropped_d;
            win_q           <= win_d;
            show_q          <= disp_ok_q;
            out_en_q        <= 1'b1;
        end
    end

    // The RAM read register is the single latency stage; out_en_q holds pix_data at 0 from reset
    always_comb begin
        pix_data = '0;
        if (out_en_q) begin
            if (!win_q) begin
                pix_data = BG_OUT;
            end else if (!show_q) begin
                pix_data = BG_IN;
            end else begin
                pix_data = rd_bit ? FG : BG_IN;
            end
        end
    end

    assign frame_done    = frame_done_q;
    assign frame_dropped = frame_dropped_q;
    assign disp_bank     = disp_bank_q;

endmodule

// File: tb/tb_edge_frame_buf.sv
// Randomised bench for edge_frame_buf against a frame-level behavioural model.
module tb_edge_frame_buf;
    import edge_pkg::*;

    localparam int N = EDGE_W * EDGE_H;

    logic        clk = 1'b0;
    logic        rstn;
    logic        edge_bit, edge_valid, frame_sync, vsync_tick;
    logic [9:0]  pix_x, pix_y;
    logic [15:0] pix_data;
    logic        frame_done, frame_dropped, disp_bank;

    edge_frame_buf dut (
        .clk           (clk),
        .rstn          (rstn),
        .edge_bit      (edge_bit),
        .edge_valid    (edge_valid),
        .frame_sync    (frame_sync),
        .vsync_tick    (vsync_tick),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .pix_data      (pix_data),
        .frame_done    (frame_done),
        .frame_dropped (frame_dropped),
        .disp_bank     (disp_bank)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int bad;

    // Reference model: two bitmaps indexed by linear pixel number, plus frame-level flags
    bit          m_mem [2][N];
    int          m_pos;
    bit          m_fren, m_ready, m_wr, m_disp, m_ok;
    logic [15:0] exp_pix;
    bit          exp_done, exp_drop;

    function automatic void model_init();
        m_pos = 0; m_fren = 1; m_ready = 0; m_wr = 0; m_disp = 1; m_ok = 0;
    endfunction

    function automatic logic [15:0] model_pix(input int x, input int y);
        int dx, dy;
        dx = x - X0;
        dy = y - Y0;
        if (x >= HOR_SCREEN || y >= VERT_SCREEN || dx < 0 || dx >= EDGE_W || dy < 0 || dy >= EDGE_H)
            return BG_OUT;
        if (!m_ok) return BG_IN;
        return m_mem[m_disp][dy*EDGE_W + dx] ? FG : BG_IN;
    endfunction

    function automatic bit pat(input int kind, input int p);
        int c, r;
        c = p % EDGE_W;
        r = p / EDGE_W;
        case (kind)
            0:       return c == r;
            1:       return (c == r) || (c + r == EDGE_W - 1);
            default: return 1'b1;
        endcase
    endfunction

    function automatic void rand_xy(output int x, output int y);
        if ($urandom_range(1, 0) == 1) begin
            x = X0 - 2 + int'($urandom_range(EDGE_W + 3, 0));
            y = Y0 - 2 + int'($urandom_range(EDGE_H + 3, 0));
        end else begin
            x = int'($urandom_range(1023, 0));
            y = int'($urandom_range(1023, 0));
        end
    endfunction

    // One clock: drive, advance model at the edge, then compare all outputs into 'bad'
    task automatic step(input bit ev, input bit eb, input bit fs, input bit vs, input int x, input int y);
        bit old_ready, set_ready;
        edge_valid = ev; edge_bit = eb; frame_sync = fs; vsync_tick = vs;
        pix_x = 10'(x); pix_y = 10'(y);
        @(posedge clk);
        exp_pix   = model_pix(x, y);
        exp_done  = 0;
        exp_drop  = 0;
        old_ready = m_ready;
        set_ready = 0;
        if (fs) begin
            m_pos = 0;
        end else if (ev) begin
            if (m_pos == 0) m_fren = !old_ready;
            if (m_fren) m_mem[m_wr][m_pos] = eb;
            if (m_pos == N - 1) begin
                if (m_fren) begin set_ready = 1; exp_done = 1; end
                else exp_drop = 1;
            end
            m_pos = (m_pos + 1) % N;
        end
        if (vs && old_ready) begin
            m_disp = m_wr; m_wr = !m_wr; m_ready = 0; m_ok = 1;
        end
        if (set_ready) m_ready = 1;
        #1;
        if (pix_data !== exp_pix || frame_done !== exp_done ||
            frame_dropped !== exp_drop || disp_bank !== m_disp) bad++;
    endtask

    task automatic stream(input int kind, input int npix, input bit vs_last,
                          output int n_done, output int n_drop, output int done_at);
        int p, iters, x, y;
        p = 0; iters = 0; n_done = 0; n_drop = 0; done_at = -1;
        while (p < npix && iters < 2 * npix + 100) begin
            iters++;
            rand_xy(x, y);
            if ($urandom_range(31, 0) == 0) begin
                step(0, 1'($urandom_range(1, 0)), 0, 0, x, y);
            end else begin
                step(1, pat(kind, p), 0, vs_last && (p == npix - 1), x, y);
                p++;
            end
            if (frame_done === 1'b1) begin n_done++; done_at = p; end
            if (frame_dropped === 1'b1) n_drop++;
        end
    endtask

    task automatic test_reset();
        bad = 0;
        rstn = 0; edge_bit = 0; edge_valid = 0; frame_sync = 0; vsync_tick = 0;
        pix_x = 10'd400; pix_y = 10'd240;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (pix_data !== 16'h0000) begin failures++; $display("FAIL reset_pix got=%h exp=0000", pix_data); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", frame_done); end
        checks++; if (frame_dropped !== 1'b0) begin failures++; $display("FAIL reset_dropped got=%b exp=0", frame_dropped); end
        checks++; if (disp_bank !== 1'b1) begin failures++; $display("FAIL reset_bank got=%b exp=1", disp_bank); end
        @(negedge clk);
        rstn = 1;
        model_init();
        step(0, 0, 0, 0, 400, 240);
        checks++; if (pix_data !== BG_IN) begin failures++; $display("FAIL reset_read_in got=%h exp=%h", pix_data, BG_IN); end
        step(0, 0, 0, 0, 0, 0);
        checks++; if (pix_data !== BG_OUT) begin failures++; $display("FAIL reset_read_out got=%h exp=%h", pix_data, BG_OUT); end
        checks++; if (disp_bank !== 1'b1) begin failures++; $display("FAIL reset_bank_after got=%b exp=1", disp_bank); end
    endtask

    task automatic test_diagonal();
        int nd, ndr, at;
        bad = 0;
        stream(0, N, 0, nd, ndr, at);
        checks++; if (nd != 1) begin failures++; $display("FAIL diag_done_count got=%0d exp=1", nd); end
        checks++; if (at != N) begin failures++; $display("FAIL diag_done_pos got=%0d exp=%0d", at, N); end
        checks++; if (ndr != 0) begin failures++; $display("FAIL diag_dropped got=%0d exp=0", ndr); end
        step(0, 0, 0, 1, 0, 0);
        checks++; if (disp_bank !== 1'b0) begin failures++; $display("FAIL diag_swap_bank got=%b exp=0", disp_bank); end
        step(0, 0, 0, 0, X0 + 5, Y0 + 5);
        checks++; if (pix_data !== FG) begin failures++; $display("FAIL diag_on got=%h exp=%h", pix_data, FG); end
        step(0, 0, 0, 0, X0 + 6, Y0 + 5);
        checks++; if (pix_data !== BG_IN) begin failures++; $display("FAIL diag_off got=%h exp=%h", pix_data, BG_IN); end
        checks++; if (bad != 0) begin failures++; $display("FAIL diag_stream_model got=%0d exp=0 mismatching cycles", bad); end
    endtask

    task automatic test_sync_collision();
        int nd, ndr, at;
        bad = 0;
        stream(1, 1000, 0, nd, ndr, at);
        checks++; if (nd + ndr != 0) begin failures++; $display("FAIL partial_pulses got=%0d exp=0", nd + ndr); end
        // frame_sync together with a valid pixel: the pixel must not count
        step(1, 1, 1, 0, 0, 0);
        stream(1, N, 1, nd, ndr, at);
        checks++; if (nd != 1) begin failures++; $display("FAIL sync_done_count got=%0d exp=1", nd); end
        checks++; if (at != N) begin failures++; $display("FAIL sync_done_pos got=%0d exp=%0d", at, N); end
        checks++; if (disp_bank !== 1'b0) begin failures++; $display("FAIL collide_no_swap got=%b exp=0", disp_bank); end
        repeat (3) step(0, 0, 0, 0, X0 + 5, Y0 + 5);
        checks++; if (disp_bank !== 1'b0) begin failures++; $display("FAIL collide_idle_bank got=%b exp=0", disp_bank); end
        checks++; if (bad != 0) begin failures++; $display("FAIL sync_stream_model got=%0d exp=0 mismatching cycles", bad); end
    endtask

    task automatic test_drop();
        int nd, ndr, at;
        bad = 0;
        stream(2, N, 0, nd, ndr, at);
        checks++; if (ndr != 1) begin failures++; $display("FAIL drop_count got=%0d exp=1", ndr); end
        checks++; if (nd != 0) begin failures++; $display("FAIL drop_done got=%0d exp=0", nd); end
        step(0, 0, 0, 1, 0, 0);
        checks++; if (disp_bank !== 1'b1) begin failures++; $display("FAIL drop_swap_bank got=%b exp=1", disp_bank); end
        step(0, 0, 0, 0, X0 + 5, Y0 + 5);
        checks++; if (pix_data !== FG) begin failures++; $display("FAIL drop_show_a_on got=%h exp=%h", pix_data, FG); end
        step(0, 0, 0, 0, X0 + 6, Y0 + 5);
        checks++; if (pix_data !== BG_IN) begin failures++; $display("FAIL drop_show_a_off got=%h exp=%h", pix_data, BG_IN); end
        checks++; if (bad != 0) begin failures++; $display("FAIL drop_stream_model got=%0d exp=0 mismatching cycles", bad); end
    endtask

    task automatic test_boundary();
        int          bx[6];
        int          by[6];
        logic [15:0] be[6];
        logic [15:0] prev;
        bx = '{X0 - 1, X0 + 157, X0 + 158, X0,  799, 1023};
        by = '{Y0,     Y0 + 157, Y0,       Y0,  479, 1023};
        be = '{BG_OUT, FG,       BG_OUT,   FG,  BG_OUT, BG_OUT};
        step(0, 0, 0, 0, X0 + 6, Y0 + 5);
        prev = BG_IN;
        for (int i = 0; i < 6; i++) begin
            pix_x = 10'(bx[i]); pix_y = 10'(by[i]);
            #2;
            checks++; if (pix_data !== prev) begin failures++; $display("FAIL bound_hold_%0d got=%h exp=%h", i, pix_data, prev); end
            step(0, 0, 0, 0, bx[i], by[i]);
            checks++; if (pix_data !== be[i]) begin failures++; $display("FAIL bound_read_%0d got=%h exp=%h", i, pix_data, be[i]); end
            prev = be[i];
        end
    endtask

    initial begin
        test_reset();
        test_diagonal();
        test_sync_collision();
        test_drop();
        test_boundary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
